// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller:
// opcodes, immediate/ALU/writeback select codes and FSM states.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'b000,
    IMM_J     = 3'b001,
    IMM_B     = 3'b010,
    IMM_I     = 3'b011,
    IMM_S     = 3'b100,
    IMM_U     = 3'b101,
    IMM_SHAMT = 3'b111
  } imm_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
  } inst_class_t;

  // alt is inst[30]; SUB only exists for register-register ops
  function automatic alu_op_e alu_from_f3(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_op
  );
    alu_op_e r;
    unique case (f3)
      3'b000: r = (alt && is_op) ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = alt ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_inst_decode.sv
// Combinational instruction decoder: IR -> datapath selects,
// instruction class flags and illegal-opcode detect.
module inst_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0]  inst_i,
  output logic [2:0]   imm_sel_o,
  output logic [3:0]   alu_op_o,
  output logic         alu_src_a_o,
  output logic         alu_src_b_o,
  output logic [1:0]   wb_sel_o,
  output inst_class_t  class_o,
  output logic         illegal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  logic       unused_bits;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign alt = inst_i[30];
  assign unused_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  logic is_op, is_opimm, is_lui, is_auipc;
  logic is_jal, is_jalr, is_br, is_ld, is_st;

  assign is_op    = (opc == OPC_OP);
  assign is_opimm = (opc == OPC_OPIMM);
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_br    = (opc == OPC_BRANCH);
  assign is_ld    = (opc == OPC_LOAD);
  assign is_st    = (opc == OPC_STORE);

  assign class_o.is_load   = is_ld;
  assign class_o.is_store  = is_st;
  assign class_o.is_branch = is_br;
  assign class_o.is_jump   = is_jal | is_jalr;

  always_comb begin
    imm_sel_o   = IMM_NONE;
    alu_op_o    = ALU_ADD;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    wb_sel_o    = WB_ALU;
    illegal_o   = 1'b0;
    unique case (1'b1)
      is_op: begin
        alu_op_o = alu_from_f3(f3, alt, 1'b1);
      end
      is_opimm: begin
        imm_sel_o   = (f3 == 3'b001 || f3 == 3'b101)
                    ? IMM_SHAMT : IMM_I;
        alu_op_o    = alu_from_f3(f3, alt, 1'b0);
        alu_src_b_o = 1'b1;
      end
      is_lui: begin
        imm_sel_o   = IMM_U;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WB_IMM;
      end
      is_auipc: begin
        imm_sel_o   = IMM_U;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
      end
      is_jal: begin
        imm_sel_o   = IMM_J;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WB_PC4;
      end
      is_jalr: begin
        imm_sel_o   = IMM_I;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WB_PC4;
      end
      is_br: begin
        imm_sel_o   = IMM_B;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
      end
      is_ld: begin
        imm_sel_o   = IMM_I;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WB_MEM;
      end
      is_st: begin
        imm_sel_o   = IMM_S;
        alu_src_b_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb
// sequencing, memory wait counter with timeout trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_dsel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap
);

  localparam int unsigned CW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);

  state_e       state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic [2:0]  d_imm_sel;
  logic [3:0]  d_alu_op;
  logic        d_src_a;
  logic        d_src_b;
  logic [1:0]  d_wb_sel;
  inst_class_t d_cls;
  logic        d_illegal;

  inst_decode u_dec (
    .inst_i      (inst),
    .imm_sel_o   (d_imm_sel),
    .alu_op_o    (d_alu_op),
    .alu_src_a_o (d_src_a),
    .alu_src_b_o (d_src_b),
    .wb_sel_o    (d_wb_sel),
    .class_o     (d_cls),
    .illegal_o   (d_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  logic waiting;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    waiting   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_dsel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    imm_sel   = IMM_NONE;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;

    // IR-derived selects are meaningful once IR holds the instruction
    if (state_q != ST_FETCH && state_q != ST_TRAP) begin
      imm_sel   = d_imm_sel;
      alu_op    = d_alu_op;
      alu_src_a = d_src_a;
      alu_src_b = d_src_b;
      wb_sel    = d_wb_sel;
    end

    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = d_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (d_cls.is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken;
          state_d = ST_FETCH;
        end else if (d_cls.is_load || d_cls.is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_dsel = 1'b1;
        mem_we   = d_cls.is_store;
        if (mem_ready) begin
          if (d_cls.is_store) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = d_cls.is_jump;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // a ready on the timeout cycle never reaches here
    if (waiting && TO_EN) begin
      if (wcnt_q == TO_VAL) begin
        state_d = ST_TRAP;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl with an instruction-level
// reference model (per-instruction phase plan) and directed pins.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [6:0] LEGAL_OPS [9] = '{
    7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
    7'h67, 7'h63, 7'h03, 7'h23
  };
  localparam logic [3:0] F3MAP [8] = '{
    4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9
  };
  localparam logic [7:0] LW_RDY = 8'b11000111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req, mem_we, mem_dsel, ir_we;
  logic        pc_we, pc_sel;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        trap;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .mem_ready (mem_ready),
    .br_taken  (br_taken),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_dsel  (mem_dsel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .imm_sel   (imm_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_dsel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic [2:0] imm_sel;
    logic       src_a;
    logic       src_b;
    logic [3:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       trap;
  } obs_t;

  typedef enum int {
    P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP
  } ph_t;

  int          checks = 0;
  int          errors = 0;
  ph_t         plan[$];
  int          wcnt;
  logic [31:0] ir;
  logic [31:0] prog[$];
  obs_t        got;
  obs_t        hist [16];

  function automatic bit legal(input logic [6:0] o);
    return o inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                     7'h67, 7'h63, 7'h03, 7'h23};
  endfunction

  function automatic obs_t expect_of(
    input ph_t p, input logic [31:0] i,
    input logic rdy, input logic tk
  );
    obs_t       e = '0;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic       alt = i[30];
    bit is_op  = (opc == 7'h33);
    bit is_imm = (opc == 7'h13);
    bit lui    = (opc == 7'h37);
    bit auipc  = (opc == 7'h17);
    bit jal    = (opc == 7'h6F);
    bit jalr   = (opc == 7'h67);
    bit br     = (opc == 7'h63);
    bit ld     = (opc == 7'h03);
    bit st     = (opc == 7'h23);
    if (p == P_FETCH) begin
      e.mem_req = 1'b1;
      e.ir_we   = rdy;
      return e;
    end
    if (p == P_TRAP) begin
      e.trap = 1'b1;
      return e;
    end
    if (legal(opc)) begin
      e.imm_sel = is_op ? 3'd0
                : is_imm ? ((f3 == 3'd1 || f3 == 3'd5) ? 3'd7 : 3'd3)
                : (ld || jalr) ? 3'd3
                : st ? 3'd4
                : br ? 3'd2
                : jal ? 3'd1
                : 3'd5;
      if (is_op || is_imm) begin
        e.alu_op = F3MAP[f3];
        if (f3 == 3'd5 && alt) e.alu_op = 4'd7;
        if (f3 == 3'd0 && alt && is_op) e.alu_op = 4'd1;
      end
      e.src_a  = auipc || jal || br;
      e.src_b  = !is_op;
      e.wb_sel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
    end
    case (p)
      P_EXEC: if (br) begin
        e.pc_we  = 1'b1;
        e.pc_sel = tk;
      end
      P_MEM: begin
        e.mem_req  = 1'b1;
        e.mem_dsel = 1'b1;
        e.mem_we   = st;
        e.pc_we    = st && rdy;
      end
      P_WB: begin
        e.reg_we = 1'b1;
        e.pc_we  = 1'b1;
        e.pc_sel = jal || jalr;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 49) == 0) return {r[31:7], 7'h7F};
    return {r[31:7], LEGAL_OPS[$urandom_range(0, 8)]};
  endfunction

  task automatic load_plan(input logic [31:0] i);
    logic [6:0] o = i[6:0];
    plan.delete();
    plan.push_back(P_DECODE);
    if (!legal(o)) begin
      plan.push_back(P_TRAP);
    end else begin
      plan.push_back(P_EXEC);
      if (o == 7'h03 || o == 7'h23) plan.push_back(P_MEM);
      if (o != 7'h63 && o != 7'h23) plan.push_back(P_WB);
    end
  endtask

  task automatic model_step(input logic rdy);
    ph_t p = plan[0];
    if (p == P_TRAP) return;
    if ((p == P_FETCH || p == P_MEM) && !rdy) begin
      if (TO != 0 && wcnt == TO) begin
        plan = {P_TRAP};
        wcnt = 0;
      end else begin
        wcnt++;
      end
      return;
    end
    wcnt = 0;
    if (p == P_FETCH) begin
      ir = (prog.size() > 0) ? prog.pop_front() : rand_inst();
      load_plan(ir);
    end else begin
      void'(plan.pop_front());
      if (plan.size() == 0) plan.push_back(P_FETCH);
    end
  endtask

  task automatic chk(input string n, input logic [3:0] a,
                     input logic [3:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  task automatic compare();
    obs_t e = expect_of(plan[0], ir, mem_ready, br_taken);
    got = {mem_req, mem_we, mem_dsel, ir_we, pc_we, pc_sel, imm_sel,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, trap};
    chk("mem_req",   4'(got.mem_req),  4'(e.mem_req));
    chk("mem_we",    4'(got.mem_we),   4'(e.mem_we));
    chk("mem_dsel",  4'(got.mem_dsel), 4'(e.mem_dsel));
    chk("ir_we",     4'(got.ir_we),    4'(e.ir_we));
    chk("pc_we",     4'(got.pc_we),    4'(e.pc_we));
    chk("pc_sel",    4'(got.pc_sel),   4'(e.pc_sel));
    chk("imm_sel",   4'(got.imm_sel),  4'(e.imm_sel));
    chk("alu_src_a", 4'(got.src_a),    4'(e.src_a));
    chk("alu_src_b", 4'(got.src_b),    4'(e.src_b));
    chk("alu_op",    got.alu_op,       e.alu_op);
    chk("reg_we",    4'(got.reg_we),   4'(e.reg_we));
    chk("wb_sel",    4'(got.wb_sel),   4'(e.wb_sel));
    chk("trap",      4'(got.trap),     4'(e.trap));
  endtask

  task automatic cyc(input logic rdy, input logic tk);
    @(negedge clk);
    mem_ready = rdy;
    br_taken  = tk;
    inst      = ir;
    #1 compare();
    @(posedge clk);
    model_step(rdy);
  endtask

  task automatic reset_mid(input bit store_chk);
    @(negedge clk);
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    inst      = ir;
    #1 compare();
    if (store_chk) chk("sw_we_before", 4'(got.mem_we), 4'd1);
    #1 rst_n = 1'b0;
    plan = {P_FETCH};
    wcnt = 0;
    #1 compare();
    if (store_chk) begin
      chk("sw_we_after", 4'(got.mem_we), 4'd0);
      chk("sw_restart", 4'({got.mem_req, got.mem_dsel}), 4'b0010);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    inst      = '0;
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    ir        = '0;
    plan      = {P_FETCH};
    wcnt      = 0;
    #2 compare();
    chk("rst_mem_req", 4'(got.mem_req), 4'd1);
    chk("rst_others", 4'(|(got & ~19'h40000)), 4'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADDI x1,x0,5
    prog.push_back(32'h00500093);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0);
      hist[k] = got;
    end
    chk("addi_ir_we", 4'(hist[0].ir_we), 4'd1);
    chk("addi_imm", 4'(hist[2].imm_sel), 4'd3);
    chk("addi_reg_we", 4'({hist[0].reg_we, hist[1].reg_we,
                           hist[2].reg_we, hist[3].reg_we}), 4'b0001);

    // LW with three wait cycles in MEM
    prog.push_back(32'h0000A103);
    for (int k = 0; k < 8; k++) begin
      cyc(LW_RDY[k], 1'b0);
      hist[k] = got;
    end
    chk("lw_mem_span", 4'({hist[3].mem_dsel, hist[4].mem_dsel,
                           hist[5].mem_dsel, hist[6].mem_dsel}), 4'hF);
    chk("lw_wb_sel", 4'(hist[7].wb_sel), 4'd1);
    chk("lw_reg_we", 4'({hist[6].reg_we, hist[7].reg_we}), 4'b0001);

    // BEQ taken then not taken
    prog.push_back(32'h00208463);
    prog.push_back(32'h00208463);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, k < 3);
      hist[k] = got;
    end
    chk("beq_fetch_sel", 4'(hist[0].pc_sel), 4'd0);
    chk("beq_t_pc", 4'({hist[2].pc_we, hist[2].pc_sel}), 4'b0011);
    chk("beq_imm", 4'(hist[2].imm_sel), 4'd2);
    chk("beq_refetch", 4'(hist[3].mem_req), 4'd1);
    chk("beq_nt_pc", 4'({hist[5].pc_we, hist[5].pc_sel}), 4'b0010);
    chk("beq_nt_refetch", 4'(hist[6].mem_req), 4'd1);
    repeat (1) cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0);

    // SRAI then SLLI
    prog.push_back(32'h4020D093);
    prog.push_back(32'h00209093);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0);
      hist[k] = got;
    end
    chk("srai_imm", 4'(hist[2].imm_sel), 4'd7);
    chk("srai_op", hist[2].alu_op, 4'd7);
    chk("slli_imm", 4'(hist[6].imm_sel), 4'd7);
    chk("slli_op", hist[6].alu_op, 4'd2);

    // illegal opcode
    prog.push_back(32'h0000007F);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1);
      hist[k] = got;
    end
    chk("ill_dec_trap", 4'(hist[1].trap), 4'd0);
    for (int k = 2; k < 6; k++) begin
      chk("ill_trap", 4'(hist[k].trap), 4'd1);
      chk("ill_enables", 4'(|{hist[k].mem_req, hist[k].mem_we,
                              hist[k].ir_we, hist[k].pc_we,
                              hist[k].reg_we}), 4'd0);
    end
    reset_mid(1'b0);

    // fetch timeout
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0);
      hist[k] = got;
    end
    chk("to_fetch5", 4'({hist[4].mem_req, hist[4].trap}), 4'b0010);
    chk("to_trap", 4'(hist[5].trap), 4'd1);
    reset_mid(1'b0);

    // ready on the timeout cycle wins
    prog.push_back(32'h00500093);
    for (int k = 0; k < 8; k++) begin
      cyc(k >= 4, 1'b0);
      hist[k] = got;
    end
    chk("to_win_dec", 4'({hist[5].trap, hist[5].imm_sel}), 4'd3);
    chk("to_win_wb", 4'(hist[7].reg_we), 4'd1);

    // reset during store MEM
    prog.push_back(32'h0020A023);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    reset_mid(1'b1);

    for (int n = 0; n < 3000; n++) begin
      if (plan[0] == P_TRAP && $urandom_range(0, 3) == 0)
        reset_mid(1'b0);
      else if ($urandom_range(0, 299) == 0)
        reset_mid(1'b0);
      else
        cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
